// File: rtl/ariane_pkg.sv
// Shared types for the SIMD ALU: lane-width modes, opcodes, the S1 control payload
// and the byte lane-boundary helper used by the segmented adder.
package ariane_pkg;

  typedef enum logic [1:0] {
    mode8    = 2'd0,
    mode16   = 2'd1,
    mode32   = 2'd2,
    modefull = 2'd3
  } vec_mode_t;

  typedef enum logic [3:0] {
    vadd  = 4'd0,
    vsub  = 4'd1,
    vavg  = 4'd2,
    vmin  = 4'd3,
    vminu = 4'd4,
    vmax  = 4'd5,
    vmaxu = 4'd6,
    vabs  = 4'd7,
    vsll  = 4'd8,
    vsrl  = 4'd9,
    vsra  = 4'd10,
    veq   = 4'd11,
    vne   = 4'd12,
    vlts  = 4'd13,
    vltu  = 4'd14,
    vcnt  = 4'd15
  } simd_op_t;

  typedef struct packed {
    simd_op_t  op;
    vec_mode_t mode;
    logic      sat;
  } simd_ctrl_t;

  // True when byte byte_idx is the least-significant byte of a lane in mode m.
  function automatic logic lane_start(vec_mode_t m, int unsigned byte_idx);
    logic r;
    case (m)
      mode8:   r = 1'b1;
      mode16:  r = (byte_idx[0] == 1'b0);
      mode32:  r = (byte_idx[1:0] == 2'b00);
      default: r = (byte_idx == 0);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/simd_alu_pipe_if.sv
// Request/response bundle of the SIMD ALU: valid/ready request with tag, valid/ready result.
interface simd_alu_pipe_if
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 4
);

  logic             valid_i;
  logic             ready_o;
  simd_op_t         op_i;
  vec_mode_t        mode_i;
  logic             sat_i;
  logic [XLEN-1:0]  a_i;
  logic [XLEN-1:0]  b_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, op_i, mode_i, sat_i, a_i, b_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );

  modport slave (
    input  valid_i, op_i, mode_i, sat_i, a_i, b_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );

endinterface

// File: rtl/simd_seg_adder.sv
// XLEN-bit adder/subtractor built from byte slices whose carry chain is cut at every
// lane boundary; reports carry-out and signed overflow per byte.
module simd_seg_adder
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              sub_i,
  input  vec_mode_t         mode_i,
  output logic [XLEN-1:0]   sum_o,
  output logic [XLEN/8-1:0] cout_o,
  output logic [XLEN/8-1:0] ovf_o
);

  localparam int unsigned NB = XLEN / 8;

  for (genvar k = 0; k < NB; k++) begin : g_byte
    logic       w_cin;
    logic       w_co;
    logic [7:0] w_bx;
    logic [7:0] w_s;

    // Subtraction is a + ~b + 1, the +1 injected at each lane's bottom byte.
    if (k == 0) begin : g_first
      assign w_cin = sub_i;
    end else begin : g_chain
      assign w_cin = lane_start(mode_i, k) ? sub_i : g_byte[k-1].w_co;
    end

    assign w_bx          = b_i[8*k +: 8] ^ {8{sub_i}};
    assign {w_co, w_s}   = 9'(a_i[8*k +: 8]) + 9'(w_bx) + 9'(w_cin);
    assign sum_o[8*k +: 8] = w_s;
    assign cout_o[k]     = w_co;
    assign ovf_o[k]      = (a_i[8*k+7] == w_bx[7]) && (w_s[7] != a_i[8*k+7]);
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage elastic SIMD ALU: S1 holds operands/control, S2 holds the packed result.
// Per-lane results are built for every lane width and selected by the S1 mode.
module simd_alu_pipe
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  simd_alu_pipe_if.slave bus
);

  localparam int unsigned NB = XLEN / 8;

  logic             r_s1_valid;
  simd_ctrl_t       r_s1_ctrl;
  logic [XLEN-1:0]  r_s1_a;
  logic [XLEN-1:0]  r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;

  logic                  w_s1_advance;
  logic                  w_ready;
  logic                  w_sub;
  logic [XLEN-1:0]       w_sum;
  logic [NB-1:0]         w_cout;
  logic [NB-1:0]         w_ovf;
  logic [3:0][XLEN-1:0]  w_res;
  logic [XLEN-1:0]       w_result;

  assign w_s1_advance = !r_s2_valid || bus.ready_i;
  assign w_ready      = !r_s1_valid || w_s1_advance;
  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = r_s2_valid;
  assign bus.result_o = r_s2_result;
  assign bus.tag_o    = r_s2_tag;

  // Everything except vadd needs a - b (sub, compares, min/max).
  assign w_sub = (r_s1_ctrl.op != vadd);

  simd_seg_adder #(.XLEN(XLEN)) u_seg_adder (
    .a_i    (r_s1_a),
    .b_i    (r_s1_b),
    .sub_i  (w_sub),
    .mode_i (r_s1_ctrl.mode),
    .sum_o  (w_sum),
    .cout_o (w_cout),
    .ovf_o  (w_ovf)
  );

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned W = 8 << m;
    if (W <= XLEN) begin : g_on
      for (genvar l = 0; l < XLEN / W; l++) begin : g_lane
        localparam int unsigned LO = l * W;
        localparam int unsigned TB = (LO + W) / 8 - 1;
        localparam int unsigned SW = $clog2(W);

        logic [W-1:0]  w_a;
        logic [W-1:0]  w_b;
        logic [W-1:0]  w_s;
        logic [W-1:0]  w_avg;
        logic [W-1:0]  w_r;
        logic [SW-1:0] w_sh;
        logic          w_lts;
        logic          w_ltu;

        assign w_a   = r_s1_a[LO +: W];
        assign w_b   = r_s1_b[LO +: W];
        assign w_s   = w_sum[LO +: W];
        assign w_sh  = w_b[SW-1:0];
        assign w_lts = w_s[W-1] ^ w_ovf[TB];
        assign w_ltu = !w_cout[TB];
        // floor((a+b+1)/2) == (a>>>1) + (b>>>1) + (a[0]|b[0]), never overflows W bits.
        assign w_avg = {w_a[W-1], w_a[W-1:1]} + {w_b[W-1], w_b[W-1:1]} + W'(w_a[0] | w_b[0]);

        always_comb begin
          w_r = '0;
          case (r_s1_ctrl.op)
            vadd, vsub: begin
              if (r_s1_ctrl.sat && w_ovf[TB])
                w_r = w_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
              else
                w_r = w_s;
            end
            vavg:    w_r = w_avg;
            vmin:    w_r = w_lts ? w_a : w_b;
            vmax:    w_r = w_lts ? w_b : w_a;
            vminu:   w_r = w_ltu ? w_a : w_b;
            vmaxu:   w_r = w_ltu ? w_b : w_a;
            vabs:    w_r = w_a[W-1] ? (~w_a + W'(1)) : w_a;
            vsll:    w_r = w_a << w_sh;
            vsrl:    w_r = w_a >> w_sh;
            vsra:    w_r = W'($signed(w_a) >>> w_sh);
            veq:     w_r = {W{w_a == w_b}};
            vne:     w_r = {W{w_a != w_b}};
            vlts:    w_r = {W{w_lts}};
            vltu:    w_r = {W{w_ltu}};
            vcnt:    w_r = W'($countones(w_a));
            default: w_r = '0;
          endcase
        end

        assign w_res[m][LO +: W] = w_r;
      end
    end else begin : g_off
      assign w_res[m] = '0;
    end
  end

  // modefull collapses to mode32 on a 32-bit datapath.
  always_comb begin
    w_result = '0;
    case (r_s1_ctrl.mode)
      mode8:    w_result = w_res[0];
      mode16:   w_result = w_res[1];
      mode32:   w_result = w_res[2];
      modefull: w_result = (XLEN == 32) ? w_res[2] : w_res[3];
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else begin
      if (w_ready) r_s1_valid <= bus.valid_i;
      if (w_s1_advance) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_result;
          r_s2_tag    <= r_s1_tag;
        end
      end
    end
  end

  // S1 payload only moves on acceptance; its valid bit alone needs reset.
  always_ff @(posedge clk_i) begin
    if (w_ready && bus.valid_i) begin
      r_s1_ctrl <= '{op: bus.op_i, mode: bus.mode_i, sat: bus.sat_i};
      r_s1_a    <= bus.a_i;
      r_s1_b    <= bus.b_i;
      r_s1_tag  <= bus.tag_i;
    end
  end

endmodule
